// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD seven-segment display back-end:
// converter states, the active-low segment table and the digit count.
package seg_pkg;

  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  // Segment patterns are written a..g from left to right, active low.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [0:6] SEG_TABLE [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  function automatic logic [0:6] seg_decode(input logic [3:0] nib);
    if (nib < 4'd10) seg_decode = SEG_TABLE[nib];
    else             seg_decode = SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble converter: samples value in IDLE,
// runs W add-3/shift iterations, then publishes four BCD digits in DONE.
module bin2bcd_seq #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] value,
  output logic [15:0]  bcd,
  output logic         conv_done
);
  import seg_pkg::*;

  localparam int SH_W = W + 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  conv_state_e     r_state;
  conv_state_e     w_next;
  logic [SH_W-1:0] r_sh;
  logic [SH_W-1:0] w_adj;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]     r_bcd;
  logic            r_done;

  // NOTE: sequential state always uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: defaults are assigned first so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_sh;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_sh[W + 4 * k +: 4] >= 4'd5) w_adj[W + 4 * k +: 4] = r_sh[W + 4 * k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sh   <= {{(4 * DIGITS){1'b0}}, value};
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
        SHIFT: begin
          r_sh  <= {w_adj[SH_W-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_bcd  <= r_sh[SH_W-1:W];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd       = r_bcd;
  assign conv_done = r_done;

endmodule

// File: rtl/seg_scan_bcd.sv
// Converts a binary register value to BCD and time-multiplexes the four
// digits onto a common-anode seven-segment display with leading-zero blanking.
module seg_scan_bcd #(
  parameter int W           = 13,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] value,
  output logic [15:0]  bcd,
  output logic         conv_done,
  output logic [3:0]   anode,
  output logic [0:6]   seg
);
  import seg_pkg::*;

  localparam int SCAN_W = $clog2(REFRESH_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

  logic [15:0]       w_bcd;
  logic              w_done;
  logic [SCAN_W-1:0] r_scan;
  logic [1:0]        r_idx;
  logic [3:0]        r_anode;
  logic [0:6]        r_seg;
  logic [3:0]        w_nib;
  logic              w_upper_zero;
  logic [0:6]        w_seg;

  bin2bcd_seq #(.W(W)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .bcd       (w_bcd),
    .conv_done (w_done)
  );

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    w_nib        = w_bcd[{r_idx, 2'b00} +: 4];
    w_upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(r_idx) && w_bcd[4 * k +: 4] != 4'd0) w_upper_zero = 1'b0;
    end
    if (BLANK_LZ != 0 && r_idx != 2'd0 && w_upper_zero) w_seg = SEG_BLANK;
    else                                                w_seg = seg_decode(w_nib);
  end

  // Outputs are registered together so anode and seg always switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan  <= '0;
      r_idx   <= 2'd0;
      r_anode <= 4'b1111;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_scan == SCAN_LAST) begin
        r_scan <= '0;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_scan <= r_scan + SCAN_W'(1);
      end
      r_anode <= ~(4'b0001 << r_idx);
      r_seg   <= w_seg;
    end
  end

  assign bcd       = w_bcd;
  assign conv_done = w_done;
  assign anode     = r_anode;
  assign seg       = r_seg;

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Self-checking bench for seg_scan_bcd: directed scenarios plus random values
// and resets, compared every cycle against an arithmetic reference model.
module tb_seg_scan_bcd;

  localparam int R = 4;
  localparam int PERIOD = 15;

  localparam logic [6:0] SEG_REF [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] r_value;
  logic [15:0] w_bcd, w_bcd_nb;
  logic        w_done, w_done_nb;
  logic [3:0]  w_anode, w_anode_nb;
  logic [0:6]  w_seg, w_seg_nb;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Reference model state
  int         m_e;
  int         m_num;
  int         m_sample;
  int         m_idx;
  bit         m_done;
  logic [3:0] m_anode;
  logic [6:0] m_seg, m_seg_nb;

  seg_scan_bcd #(.W(13), .REFRESH_DIV(R), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(r_value), .bcd(w_bcd), .conv_done(w_done),
    .anode(w_anode), .seg(w_seg)
  );

  seg_scan_bcd #(.W(13), .REFRESH_DIV(R), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .value(r_value), .bcd(w_bcd_nb), .conv_done(w_done_nb),
    .anode(w_anode_nb), .seg(w_seg_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input int num, input int idx, input bit blank);
    int p = 1;
    for (int k = 0; k < idx; k++) p *= 10;
    if (blank && idx > 0 && num < p) return 7'b1111111;
    return SEG_REF[4'((num / p) % 10)];
  endfunction

  // Model: conversions start every PERIOD edges after reset, result lands on
  // the last edge of the period; digit index advances every R edges and the
  // display shows the previous cycle's index and result.
  always @(posedge clk) begin
    if (rst) begin
      m_e      = 0;
      m_num    = 0;
      m_sample = 0;
      m_done   = 0;
      m_anode  = 4'b1111;
      m_seg    = 7'b1111111;
      m_seg_nb = 7'b1111111;
    end else begin
      m_idx    = (m_e / R) % 4;
      m_anode  = ~(4'b0001 << m_idx);
      m_seg    = ref_seg(m_num, m_idx, 1'b1);
      m_seg_nb = ref_seg(m_num, m_idx, 1'b0);
      if (m_e % PERIOD == 0) m_sample = int'(r_value);
      m_done = (m_e % PERIOD == PERIOD - 1);
      if (m_done) m_num = m_sample;
      m_e++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd",       32'(w_bcd),      32'(to_bcd(m_num)));
      check("conv_done", 32'(w_done),     32'(m_done));
      check("anode",     32'(w_anode),    32'(m_anode));
      check("seg",       32'(w_seg),      32'(m_seg));
      check("seg_nb",    32'(w_seg_nb),   32'(m_seg_nb));
      check("anode_nb",  32'(w_anode_nb), 32'(m_anode));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    bit found;
    rst     = 1'b1;
    r_value = 13'd8191;
    cycles(3);
    chk_en = 1;
    check("rst_anode", 32'(w_anode), 32'h0000000f);
    check("rst_seg",   32'(w_seg),   32'h0000007f);
    check("rst_bcd",   32'(w_bcd),   32'h00000000);

    // Max value, first cycle after release, frame order 1,9,1,8
    rst = 1'b0;
    cycles(1);
    check("first_anode", 32'(w_anode), 32'h0000000e);
    check("first_seg",   32'(w_seg),   32'h00000001);
    cycles(13);
    check("max_done_early", 32'(w_done), 32'h0);
    cycles(1);
    check("max_done", 32'(w_done), 32'h1);
    check("max_bcd",  32'(w_bcd),  32'h00008191);
    cycles(2 * 4 * R);

    // Leading-zero blanking with 42
    r_value = 13'd42;
    reset_pulse(2);
    cycles(PERIOD);
    check("lz_bcd", 32'(w_bcd), 32'h00000042);
    found = 0;
    for (int i = 0; i < 4 * R + 1 && !found; i++) begin
      cycles(1);
      if (w_anode == 4'b1011) begin
        found = 1;
        check("lz_digit2_blank",  32'(w_seg),    32'h0000007f);
        check("lz_digit2_noblnk", 32'(w_seg_nb), 32'h00000001);
      end
    end
    check("lz_digit2_seen", 32'(found), 32'h1);
    cycles(4 * R);

    // Value change on the 5th SHIFT cycle is ignored until next sample
    r_value = 13'd1234;
    reset_pulse(2);
    cycles(5);
    r_value = 13'd5678;
    cycles(PERIOD - 5);
    check("mid_bcd1", 32'(w_bcd), 32'h00001234);
    cycles(PERIOD);
    check("mid_bcd2", 32'(w_bcd), 32'h00005678);

    // Reset mid-conversion aborts it
    r_value = 13'd999;
    reset_pulse(2);
    cycles(6);
    rst = 1'b1;
    cycles(1);
    check("abort_bcd",  32'(w_bcd),  32'h0);
    check("abort_done", 32'(w_done), 32'h0);
    cycles(1);
    rst = 1'b0;
    cycles(PERIOD - 1);
    check("abort_bcd_pre", 32'(w_bcd), 32'h0);
    cycles(1);
    check("abort_bcd_new", 32'(w_bcd), 32'h00000999);

    // Zero value: one pulse per period
    r_value = 13'd0;
    reset_pulse(2);
    pulses = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      cycles(1);
      if (w_done) pulses++;
    end
    check("zero_pulses", 32'(pulses), 32'd3);
    check("zero_bcd",    32'(w_bcd),  32'h0);
    cycles(4 * R);

    // Random values and occasional resets
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(9) == 0) reset_pulse(int'($urandom_range(1, 3)));
      case ($urandom_range(3))
        0:       r_value = 13'd0;
        1:       r_value = 13'd8191;
        default: r_value = 13'($urandom_range(8191));
      endcase
      cycles(int'($urandom_range(1, 40)));
    end
    cycles(PERIOD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
